// File: rtl/mmio_pkg.sv
// Shared constants for the memory-mapped button/output responder: default
// addresses, status/control bit positions and debouncer state encoding.
package mmio_pkg;

    localparam logic [31:0] BUTTON_ADDR_DEFAULT = 32'd1000;
    localparam logic [31:0] OUTPUT_ADDR_DEFAULT = 32'd2000;

    localparam int unsigned LEVEL_BIT       = 0;
    localparam int unsigned PENDING_BIT     = 1;
    localparam int unsigned CLR_PENDING_BIT = 1;
    localparam int unsigned CLR_COUNT_BIT   = 2;
    localparam int unsigned COUNT_LSB       = 16;
    localparam int unsigned COUNT_MSB       = 23;

    localparam logic [1:0] ST_STABLE_LOW  = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH   = 2'd1;
    localparam logic [1:0] ST_STABLE_HIGH = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW    = 2'd3;

    function automatic logic [31:0] status_word(input logic level,
                                                input logic pending,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                      = '0;
        s[LEVEL_BIT]           = level;
        s[PENDING_BIT]         = pending;
        s[COUNT_MSB:COUNT_LSB] = count;
        return s;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a counting debounce FSM. `rise` is high
// in the cycle whose closing edge raises `level`, so event logic updates on that same edge.
module button_debouncer
    import mmio_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_in,
    output logic level,
    output logic rise
);

    localparam int CW = $clog2(int'(DEBOUNCE_CYCLES) + 1);
    localparam logic [CW-1:0] CNT_TARGET = CW'(DEBOUNCE_CYCLES);

    logic          sync1_q, sync_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_STABLE_LOW: if (sync_q) begin
                state_d = ST_WAIT_HIGH;
                cnt_d   = CW'(1);
            end
            ST_STABLE_HIGH: if (!sync_q) begin
                state_d = ST_WAIT_LOW;
                cnt_d   = CW'(1);
            end
            ST_WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = ST_STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q + CW'(1) == CNT_TARGET) begin
                    state_d = ST_STABLE_HIGH;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_LOW: begin
                if (sync_q) begin
                    state_d = ST_STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q + CW'(1) == CNT_TARGET) begin
                    state_d = ST_STABLE_LOW;
                    level_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_STABLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            state_q <= ST_STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= button_in;
            sync_q  <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level = level_q;
    assign rise  = level_d & ~level_q;

endmodule

// File: rtl/mmio_io_controller.sv
// I/O responder beside the data RAM: button status/control register and a
// held output register, both decoded combinationally from the data address.
module mmio_io_controller
    import mmio_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [31:0] BUTTON_ADDR     = BUTTON_ADDR_DEFAULT,
    parameter logic [31:0] OUTPUT_ADDR     = OUTPUT_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        button_in,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    output logic        sel_io,
    output logic [31:0] q_io,
    output logic [31:0] out_reg,
    output logic        out_strobe
);

    logic        level, rise;
    logic        hit_button, hit_output;
    logic        pending_q, pending_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] out_reg_q, out_reg_d;
    logic        strobe_q, strobe_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debouncer (
        .clock     (clock),
        .reset     (reset),
        .button_in (button_in),
        .level     (level),
        .rise      (rise)
    );

    assign hit_button = (address_dmem == BUTTON_ADDR);
    assign hit_output = (address_dmem == OUTPUT_ADDR);

    // Clears are applied first so a press on the same edge overrides them.
    always_comb begin
        pending_d = pending_q;
        count_d   = count_q;
        if (wren && hit_button) begin
            if (data[CLR_PENDING_BIT]) pending_d = 1'b0;
            if (data[CLR_COUNT_BIT])   count_d   = 8'd0;
        end
        if (rise) begin
            pending_d = 1'b1;
            count_d   = count_d + 8'd1;
        end
        strobe_d  = wren && hit_output;
        out_reg_d = strobe_d ? data : out_reg_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
            count_q   <= 8'd0;
            out_reg_q <= 32'd0;
            strobe_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            out_reg_q <= out_reg_d;
            strobe_q  <= strobe_d;
        end
    end

    assign sel_io     = hit_button | hit_output;
    assign q_io       = hit_button ? status_word(level, pending_q, count_q) :
                        hit_output ? out_reg_q : 32'd0;
    assign out_reg    = out_reg_q;
    assign out_strobe = strobe_q;

endmodule

// File: tb/tb_mmio_io_controller.sv
// Bench for mmio_io_controller: decode vector table, hand-written debounce
// corner sequences, then random traffic against a behavioural model.
module tb_mmio_io_controller;

    localparam int D = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        button_in = 1'b0;
    logic [31:0] address_dmem = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] data = 32'd0;
    logic        sel_io;
    logic [31:0] q_io;
    logic [31:0] out_reg;
    logic        out_strobe;

    int checks_total  = 0;
    int checks_passed = 0;

    mmio_io_controller #(.DEBOUNCE_CYCLES(16'd4)) dut (
        .clock        (clock),
        .reset        (reset),
        .button_in    (button_in),
        .address_dmem (address_dmem),
        .wren         (wren),
        .data         (data),
        .sel_io       (sel_io),
        .q_io         (q_io),
        .out_reg      (out_reg),
        .out_strobe   (out_strobe)
    );

    always #5 clock = ~clock;

    // Behavioural model: level flips once the synchronized input has disagreed
    // with it for D consecutive samples; a flip to 1 is a press.
    logic        m_s1, m_s2, m_lvl, m_pend, m_strobe, m_rise;
    int          m_run;
    logic [7:0]  m_cnt;
    logic [31:0] m_out;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_pend = 0; m_strobe = 0;
            m_run = 0; m_cnt = 0; m_out = 0;
        end else begin
            m_rise = 0;
            if (m_s2 != m_lvl) m_run = m_run + 1; else m_run = 0;
            if (m_run == D) begin
                m_lvl  = ~m_lvl;
                m_run  = 0;
                m_rise = m_lvl;
            end
            if (wren && address_dmem == 32'd1000) begin
                if (data[1]) m_pend = 0;
                if (data[2]) m_cnt  = 0;
            end
            if (m_rise) begin
                m_pend = 1;
                m_cnt  = m_cnt + 8'd1;
            end
            m_strobe = wren && address_dmem == 32'd2000;
            if (m_strobe) m_out = data;
            m_s2 = m_s1;
            m_s1 = button_in;
        end
    end

    function automatic logic [31:0] model_q(input logic [31:0] a);
        if (a == 32'd1000) return {8'd0, m_cnt, 14'd0, m_pend, m_lvl};
        if (a == 32'd2000) return m_out;
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
        address_dmem = a;
        wren         = w;
        data         = d;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic        exp_sel;
        logic [31:0] exp_q;
        logic [31:0] exp_out;
        logic        exp_strobe;
    } vec_t;

    vec_t vecs[12];
    int   hold_left;

    initial begin
        // Each row: inputs for one cycle, and the outputs expected before its edge.
        vecs[0]  = '{32'd0,    1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
        vecs[1]  = '{32'd1000, 1'b0, 32'h0,         1'b1, 32'h0,         32'h0,         1'b0};
        vecs[2]  = '{32'd2000, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0,         32'h0,         1'b0};
        vecs[3]  = '{32'd2000, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[4]  = '{32'd2001, 1'b1, 32'h1234_5678, 1'b0, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{32'd2000, 1'b0, 32'h0,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'd2000, 1'b1, 32'h1,         1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{32'd2000, 1'b1, 32'h2,         1'b1, 32'h1,         32'h1,         1'b1};
        vecs[8]  = '{32'd1000, 1'b0, 32'h0,         1'b1, 32'h0,         32'h2,         1'b1};
        vecs[9]  = '{32'd1000, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h0,         32'h2,         1'b0};
        vecs[10] = '{32'd0,    1'b1, 32'h5,         1'b0, 32'h0,         32'h2,         1'b0};
        vecs[11] = '{32'd999,  1'b0, 32'h0,         1'b0, 32'h0,         32'h2,         1'b0};

        repeat (3) @(negedge clock);
        drive(32'd1000, 1'b0, 32'h0);
        #1 check("rst_q_1000", q_io, 32'h0);
        check("rst_out_reg", out_reg, 32'h0);
        check("rst_strobe", {31'd0, out_strobe}, 32'h0);
        drive(32'd0, 1'b0, 32'h0);
        #1 check("rst_sel_0", {31'd0, sel_io}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            #1;
            check($sformatf("vec%0d_sel", i), {31'd0, sel_io}, {31'd0, vecs[i].exp_sel});
            check($sformatf("vec%0d_q", i), q_io, vecs[i].exp_q);
            check($sformatf("vec%0d_out", i), out_reg, vecs[i].exp_out);
            check($sformatf("vec%0d_strobe", i), {31'd0, out_strobe}, {31'd0, vecs[i].exp_strobe});
            tick(1);
        end

        // Clean press and release.
        drive(32'd1000, 1'b0, 32'h0);
        button_in = 1'b1;
        tick(5);
        check("press_before_E5", q_io, 32'h0);
        tick(1);
        check("press_at_E5", q_io, 32'h0001_0003);
        button_in = 1'b0;
        tick(5);
        check("release_before_E5", q_io, 32'h0001_0003);
        tick(1);
        check("release_at_E5", q_io, 32'h0001_0002);

        // Bounce: high 3, low 1, then held high.
        drive(32'd1000, 1'b1, 32'h6);
        tick(1);
        wren = 1'b0;
        check("clear_all", q_io, 32'h0);
        button_in = 1'b1;
        tick(3);
        button_in = 1'b0;
        tick(1);
        button_in = 1'b1;
        tick(5);
        check("bounce_before", q_io, 32'h0);
        tick(1);
        check("bounce_level", q_io, 32'h0001_0003);

        // Press event coinciding with a clear of both pending and count.
        button_in = 1'b0;
        tick(6);
        check("bounce_release", q_io, 32'h0001_0002);
        button_in = 1'b1;
        tick(5);
        drive(32'd1000, 1'b1, 32'h6);
        tick(1);
        wren = 1'b0;
        check("event_beats_clear", q_io, 32'h0001_0003);
        drive(32'd1000, 1'b1, 32'h2);
        tick(1);
        wren = 1'b0;
        check("clear_pending", q_io, 32'h0001_0001);
        drive(32'd1000, 1'b1, 32'h4);
        tick(1);
        wren = 1'b0;
        check("clear_count", q_io, 32'h0000_0001);

        // 256 presses wrap the count back to zero.
        button_in = 1'b0;
        tick(6);
        for (int i = 0; i < 256; i++) begin
            button_in = 1'b1;
            tick(6);
            button_in = 1'b0;
            tick(6);
            if (i == 254) check("count_255", q_io, 32'h00FF_0002);
        end
        check("count_wrap", q_io, 32'h0000_0002);

        // Reset during WAIT_HIGH and during a strobe, button held through release.
        button_in = 1'b1;
        tick(3);
        drive(32'd2000, 1'b1, 32'hA5A5_0001);
        tick(1);
        wren = 1'b0;
        check("pre_rst_strobe", {31'd0, out_strobe}, 32'h1);
        check("pre_rst_out", out_reg, 32'hA5A5_0001);
        #2 reset = 1'b1;
        #1;
        check("async_rst_out", out_reg, 32'h0);
        check("async_rst_strobe", {31'd0, out_strobe}, 32'h0);
        check("async_rst_q2000", q_io, 32'h0);
        address_dmem = 32'd1000;
        #1 check("async_rst_q1000", q_io, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        tick(5);
        check("post_rst_before", q_io, 32'h0);
        tick(1);
        check("post_rst_press", q_io, 32'h0001_0003);

        // Random traffic against the model.
        hold_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold_left == 0) begin
                button_in = ~button_in;
                hold_left = $urandom_range(1, 8);
            end
            hold_left--;
            case ($urandom_range(0, 4))
                0: address_dmem = 32'd1000;
                1: address_dmem = 32'd2000;
                2: address_dmem = 32'd2001;
                3: address_dmem = 32'd0;
                default: address_dmem = $urandom;
            endcase
            wren = ($urandom_range(0, 3) == 0);
            data = $urandom;
            #1;
            check("rnd_sel", {31'd0, sel_io},
                  {31'd0, (address_dmem == 32'd1000) || (address_dmem == 32'd2000)});
            check("rnd_q", q_io, model_q(address_dmem));
            check("rnd_out", out_reg, m_out);
            check("rnd_strobe", {31'd0, out_strobe}, {31'd0, m_strobe});
            tick(1);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
